// File: rtl/unified_mem_arbiter_pkg.sv
// Shared widths, response-state encoding and the starvation-limit helper for the
// unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 6;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned STARVE_W       = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_state_e;

    // Out-of-range limits are clamped into 1..15 so the counter can always reach its limit.
    function automatic logic [STARVE_W-1:0] starve_limit(int unsigned max_denials);
        if (max_denials < 1) begin
            return STARVE_W'(1);
        end else if (max_denials > 15) begin
            return STARVE_W'(15);
        end
        return STARVE_W'(max_denials);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, load/store port and memory-side signals of the arbiter, bundled into
// one interface: slave is the arbiter's view, master is the surrounding core/memory.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = mem_arb_pkg::DATA_W_DEFAULT
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating, clearable denial counter; at_max_o flags that the fetch port is owed a grant.
module starve_counter
    import mem_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic [STARVE_W-1:0] limit_i,
    output logic                at_max_o
);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == limit_i);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter: data accesses win unless fetch has been denied
// STARVE_MAX times in a row; read data returns one cycle after the grant.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    unified_mem_arbiter_if.slave        bus_io
);

    localparam logic [STARVE_W-1:0] Limit = starve_limit(STARVE_MAX);

    logic       if_gnt, d_gnt;
    logic       starve_at_max;
    rsp_state_e state_q, state_d;

    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic [DATA_W-1:0] if_hold_q, if_hold_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;

    // Grants are forced low during reset so nothing reaches the memory.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst_i) begin
            if (bus_io.d_req && !(bus_io.if_req && starve_at_max)) begin
                d_gnt = 1'b1;
            end else if (bus_io.if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    starve_counter u_starve (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (bus_io.if_req & ~if_gnt),
        .clr_i    (if_gnt | ~bus_io.if_req),
        .limit_i  (Limit),
        .at_max_o (starve_at_max)
    );

    always_comb begin
        bus_io.mem_addr = '0;
        if (if_gnt) begin
            bus_io.mem_addr = bus_io.if_addr;
        end else if (d_gnt) begin
            bus_io.mem_addr = bus_io.d_addr;
        end
    end

    assign bus_io.mem_we    = d_gnt & bus_io.d_we;
    assign bus_io.mem_wdata = bus_io.d_wdata;
    assign bus_io.if_gnt    = if_gnt;
    assign bus_io.d_gnt     = d_gnt;

    always_comb begin
        state_d = RSP_NONE;
        rsp_d   = rsp_q;
        if (if_gnt) begin
            state_d = RSP_IF;
            rsp_d   = bus_io.mem_rdata;
        end else if (d_gnt) begin
            state_d = RSP_D;
            rsp_d   = bus_io.d_we ? '0 : bus_io.mem_rdata;
        end
    end

    // The non-owner keeps showing the last response it was given.
    always_comb begin
        if_hold_d = if_hold_q;
        d_hold_d  = d_hold_q;
        unique case (state_q)
            RSP_IF:  if_hold_d = rsp_q;
            RSP_D:   d_hold_d  = rsp_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RSP_NONE;
            rsp_q     <= '0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

    assign bus_io.if_rvalid = (state_q == RSP_IF);
    assign bus_io.d_rvalid  = (state_q == RSP_D);
    assign bus_io.if_rdata  = (state_q == RSP_IF) ? rsp_q : if_hold_q;
    assign bus_io.d_rdata   = (state_q == RSP_D) ? rsp_q : d_hold_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: the driver predicts grants and responses from a behavioural model
// and queues them; a negedge monitor compares every response the arbiter presents.
module tb_unified_mem_arbiter;

    localparam int SM = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst;
    bit   mem_init;
    int   cyc;
    int   vectors;
    int   miscompares;

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(
        .ADDR_W     (6),
        .DATA_W     (32),
        .STARVE_MAX (SM)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    // Memory array outside the arbiter, plus the model's view of its contents.
    logic [31:0] mem_arr [64];
    logic [31:0] ref_mem [64];
    rsp_t        if_q[$];
    rsp_t        d_q[$];
    logic [31:0] last_if;
    logic [31:0] last_d;
    int          starve;

    function automatic logic [31:0] seed_word(int i);
        return 32'hA5C3_0000 ^ (i * 32'h0101_0107);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= seed_word(i);
        end else if (bus.mem_we) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem_arr[bus.mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: responses are due exactly one cycle after their grant.
    always @(negedge clk) begin : monitor
        bit ev_if, ev_d;
        ev_if = (if_q.size() > 0) && (if_q[0].due == cyc);
        ev_d  = (d_q.size() > 0) && (d_q[0].due == cyc);
        check("if_rvalid", 32'(bus.if_rvalid), 32'(ev_if));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(ev_d));
        if (ev_if) begin
            last_if = if_q[0].data;
            void'(if_q.pop_front());
        end
        if (ev_d) begin
            last_d = d_q[0].data;
            void'(d_q.pop_front());
        end
        check("if_rdata", bus.if_rdata, last_if);
        check("d_rdata", bus.d_rdata, last_d);
    end

    // Apply one cycle's requests (already inside the cycle), check grants, update model.
    task automatic drive_now(input bit ireq, input logic [5:0] iaddr, input bit dreq,
                             input bit dwe, input logic [5:0] daddr, input logic [31:0] dwd,
                             output bit eig, output bit edg);
        logic [5:0] eaddr;
        bus.if_req  = ireq;
        bus.if_addr = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwd;
        #1;
        if (rst) begin
            eig = 1'b0;
            edg = 1'b0;
        end else begin
            edg = dreq && !(ireq && starve == SM);
            eig = ireq && !edg;
        end
        eaddr = eig ? iaddr : (edg ? daddr : 6'd0);
        check("if_gnt", 32'(bus.if_gnt), 32'(eig));
        check("d_gnt", 32'(bus.d_gnt), 32'(edg));
        check("mem_we", 32'(bus.mem_we), 32'(edg && dwe));
        check("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
        if (rst) begin
            starve = 0;
        end else begin
            if (eig) if_q.push_back('{due: cyc + 1, data: ref_mem[iaddr]});
            if (edg) begin
                if (dwe) begin
                    d_q.push_back('{due: cyc + 1, data: 32'd0});
                    ref_mem[daddr] = dwd;
                end else begin
                    d_q.push_back('{due: cyc + 1, data: ref_mem[daddr]});
                end
            end
            if (!ireq || eig) starve = 0;
            else if (starve < SM) starve++;
        end
    endtask

    task automatic drive(input bit ireq, input logic [5:0] iaddr, input bit dreq,
                         input bit dwe, input logic [5:0] daddr, input logic [31:0] dwd,
                         output bit eig, output bit edg);
        @(posedge clk);
        #1;
        drive_now(ireq, iaddr, dreq, dwe, daddr, dwd, eig, edg);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit         ig, dg;
        int         fetch_cnt;
        bit         i_pend, d_pend, d_we_r;
        logic [5:0] i_addr, d_addr_r;
        logic [31:0] d_wd;

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        starve      = 0;
        last_if     = '0;
        last_d      = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
        rst      = 1'b1;
        mem_init = 1'b1;

        // Held in reset with both ports requesting: nothing granted or returned.
        drive(1, 6'd1, 1, 1, 6'd2, 32'hDEAD_BEEF, ig, dg);
        drive(1, 6'd1, 1, 1, 6'd2, 32'hDEAD_BEEF, ig, dg);

        // Release mid-cycle: grants appear within the same cycle.
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        drive_now(1, 6'd1, 1, 0, 6'd2, 32'd0, ig, dg);

        // Seed address 3 with an instruction, then fetch it.
        drive(0, 6'd0, 1, 1, 6'd3, 32'h00F0_D193, ig, dg);
        drive(1, 6'd3, 0, 0, 6'd0, 32'd0, ig, dg);
        // Store then load at address 12.
        drive(0, 6'd0, 1, 1, 6'd12, 32'd34, ig, dg);
        drive(0, 6'd0, 1, 0, 6'd12, 32'd0, ig, dg);
        // Alternation: data in one cycle, fetch in the next.
        drive(0, 6'd0, 1, 0, 6'd12, 32'd0, ig, dg);
        drive(1, 6'd3, 0, 0, 6'd0, 32'd0, ig, dg);
        drive(0, 6'd0, 0, 0, 6'd0, 32'd0, ig, dg);

        // Contention: 15 cycles with both ports held gives exactly 3 fetch grants.
        fetch_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive(1, 6'd5, 1, 1, 6'd7, 32'h1234_0000 + 32'(i), ig, dg);
            if (bus.if_gnt === 1'b1) fetch_cnt++;
        end
        check("fetch_grants", 32'(fetch_cnt), 32'd3);
        drive(0, 6'd0, 0, 0, 6'd0, 32'd0, ig, dg);

        // Randomised traffic honouring the hold-until-grant rule, with occasional cancels.
        i_pend = 1'b0;
        d_pend = 1'b0;
        i_addr = '0;
        d_addr_r = '0;
        d_we_r = 1'b0;
        d_wd = '0;
        for (int n = 0; n < 1500; n++) begin
            if (i_pend && $urandom_range(0, 9) == 0) begin
                i_pend = 1'b0;
            end else if (!i_pend) begin
                i_pend = ($urandom_range(0, 99) < 55);
                i_addr = 6'($urandom_range(0, 63));
            end
            if (d_pend && $urandom_range(0, 9) == 0) begin
                d_pend = 1'b0;
            end else if (!d_pend) begin
                d_pend   = ($urandom_range(0, 99) < 70);
                d_we_r   = $urandom_range(0, 1) == 1;
                d_addr_r = 6'($urandom_range(0, 63));
                d_wd     = $urandom;
            end
            drive(i_pend, i_addr, d_pend, d_we_r, d_addr_r, d_wd, ig, dg);
            if (ig) i_pend = 1'b0;
            if (dg) d_pend = 1'b0;
        end
        drive(0, 6'd0, 0, 0, 6'd0, 32'd0, ig, dg);

        // Reset pulse right after a fetch grant: the owed response is dropped.
        drive(1, 6'd9, 0, 0, 6'd0, 32'd0, ig, dg);
        rst = 1'b1;
        #1;
        check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_starve_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
        if_q.delete();
        d_q.delete();
        last_if = '0;
        last_d  = '0;
        starve  = 0;
        bus.if_req = 1'b0;
        rst = 1'b0;
        drive(0, 6'd0, 0, 0, 6'd0, 32'd0, ig, dg);
        drive(0, 6'd0, 0, 0, 6'd0, 32'd0, ig, dg);

        @(posedge clk);
        #1;
        check("queues_drained", 32'(if_q.size() + d_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
